// File: rtl/rgb_duty_to_hsv_if.sv
// Handshake and data bundle between the duty-cycle detectors, the
// RGB-to-HSV converter and the colour display/report stage.
interface rgb_duty_to_hsv_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] red_duty;
   logic [7:0] green_duty;
   logic [7:0] blue_duty;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] hue;
   logic [6:0] saturation;
   logic [6:0] value;
   logic       clamped;

   // Producer/consumer side (drives the duty triple, accepts the HSV result)
   modport master (
      output in_valid, red_duty, green_duty, blue_duty, out_ready,
      input  in_ready, out_valid, hue, saturation, value, clamped
   );

   // Converter side
   modport slave (
      input  in_valid, red_duty, green_duty, blue_duty, out_ready,
      output in_ready, out_valid, hue, saturation, value, clamped
   );
endinterface

// File: rtl/rgb_duty_to_hsv.sv
// RGB duty triple (percent) to HSV converter. One restoring divider is shared
// between the saturation and hue quotients, so every conversion takes the
// same number of cycles regardless of the input values.
module rgb_duty_to_hsv #(
   parameter int DUTY_MAX  = 100,
   parameter int DIV_WIDTH = 14
) (
   input logic              clock,
   input logic              reset,
   rgb_duty_to_hsv_if.slave bus
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CALC    = 3'd1;
   localparam logic [2:0] DIV_SAT = 3'd2;
   localparam logic [2:0] DIV_HUE = 3'd3;
   localparam logic [2:0] FINAL   = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;

   localparam int                   CW        = $clog2(DIV_WIDTH + 1);
   localparam logic [CW-1:0]        LAST_STEP = CW'(DIV_WIDTH - 1);
   localparam logic [7:0]           DUTY_CAP  = 8'(DUTY_MAX);
   localparam logic [DIV_WIDTH-1:0] SAT_SCALE = DIV_WIDTH'(100);
   localparam logic [DIV_WIDTH-1:0] HUE_SCALE = DIV_WIDTH'(60);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

   // ---------------- state ----------------
   logic [2:0]           state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   logic [7:0]           red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic                 clamp_pend_q, clamp_pend_d;
   logic [7:0]           max_q, max_d, delta_q, delta_d;
   logic                 diff_neg_q, diff_neg_d;
   logic [1:0]           sector_q, sector_d;
   logic [DIV_WIDTH-1:0] hue_num_q, hue_num_d;
   logic [DIV_WIDTH-1:0] div_num_q, div_num_d, div_den_q, div_den_d;
   logic [DIV_WIDTH-1:0] div_rem_q, div_rem_d, div_quo_q, div_quo_d;
   logic [CW-1:0]        step_q, step_d;
   logic [6:0]           sat_res_q, sat_res_d;
   logic                 out_valid_q, out_valid_d;
   logic [8:0]           hue_q, hue_d;
   logic [6:0]           saturation_q, saturation_d, value_q, value_d;
   logic                 clamped_q, clamped_d;

   // ---------------- input clamp ----------------
   logic [7:0] duty_raw  [3];
   logic [7:0] duty_clip [3];
   logic [2:0] duty_over;

   assign duty_raw[0] = bus.red_duty;
   assign duty_raw[1] = bus.green_duty;
   assign duty_raw[2] = bus.blue_duty;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_clamp
         assign duty_over[gi] = duty_raw[gi] > DUTY_CAP;
         assign duty_clip[gi] = duty_over[gi] ? DUTY_CAP : duty_raw[gi];
      end
   endgenerate

   // ---------------- CALC datapath ----------------
   logic [7:0] calc_max, calc_min, calc_a, calc_b, calc_delta, calc_abs;
   logic [1:0] calc_sector;

   // Pick max (ties favour R, then G), min, and the operand pair of the signed diff
   always_comb begin
      calc_max    = red_q;
      calc_sector = 2'd0;
      calc_a      = green_q;
      calc_b      = blue_q;
      if (red_q >= green_q && red_q >= blue_q) begin
         calc_max    = red_q;
         calc_sector = 2'd0;
         calc_a      = green_q;
         calc_b      = blue_q;
      end else if (green_q >= blue_q) begin
         calc_max    = green_q;
         calc_sector = 2'd1;
         calc_a      = blue_q;
         calc_b      = red_q;
      end else begin
         calc_max    = blue_q;
         calc_sector = 2'd2;
         calc_a      = red_q;
         calc_b      = green_q;
      end
      calc_min = red_q;
      if (green_q < calc_min) calc_min = green_q;
      if (blue_q < calc_min)  calc_min = blue_q;
      calc_delta = calc_max - calc_min;
      calc_abs   = (calc_a < calc_b) ? (calc_b - calc_a) : (calc_a - calc_b);
   end

   // ---------------- restoring divider step ----------------
   logic [DIV_WIDTH:0]   div_trial;
   logic                 div_fits;
   logic [DIV_WIDTH-1:0] div_rem_step, div_quo_step;

   assign div_trial    = {div_rem_q, div_num_q[DIV_WIDTH-1]};
   assign div_fits     = div_trial >= {1'b0, div_den_q};
   assign div_rem_step = div_fits ? DIV_WIDTH'(div_trial - {1'b0, div_den_q})
                                  : DIV_WIDTH'(div_trial);
   assign div_quo_step = {div_quo_q[DIV_WIDTH-2:0], div_fits};

   // ---------------- FINAL hue assembly ----------------
   logic [9:0] hue_quo, hue_base, hue_calc;

   // Place the hue quotient in its sector; red wraps negative offsets through 360
   always_comb begin
      hue_quo  = 10'(div_quo_q);
      hue_base = (sector_q == 2'd1) ? 10'd120 : (sector_q == 2'd2) ? 10'd240 : 10'd0;
      if (sector_q == 2'd0 && diff_neg_q) hue_calc = 10'd360 - hue_quo;
      else if (diff_neg_q)                hue_calc = hue_base - hue_quo;
      else                                hue_calc = hue_base + hue_quo;
      if (hue_calc == 10'd360) hue_calc = 10'd0;
      if (delta_q == 8'd0)     hue_calc = 10'd0;
   end

   // Next-state logic for the conversion sequence and output registers
   always_comb begin
      state_d      = state_q;
      in_ready_d   = 1'b0;
      red_d        = red_q;
      green_d      = green_q;
      blue_d       = blue_q;
      clamp_pend_d = clamp_pend_q;
      max_d        = max_q;
      delta_d      = delta_q;
      diff_neg_d   = diff_neg_q;
      sector_d     = sector_q;
      hue_num_d    = hue_num_q;
      div_num_d    = div_num_q;
      div_den_d    = div_den_q;
      div_rem_d    = div_rem_q;
      div_quo_d    = div_quo_q;
      step_d       = step_q;
      sat_res_d    = sat_res_q;
      out_valid_d  = out_valid_q;
      hue_d        = hue_q;
      saturation_d = saturation_q;
      value_d      = value_q;
      clamped_d    = clamped_q;
      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               red_d        = duty_clip[0];
               green_d      = duty_clip[1];
               blue_d       = duty_clip[2];
               clamp_pend_d = |duty_over;
               in_ready_d   = 1'b0;
               state_d      = CALC;
            end
         end
         CALC: begin
            max_d      = calc_max;
            delta_d    = calc_delta;
            diff_neg_d = calc_a < calc_b;
            sector_d   = calc_sector;
            hue_num_d  = DIV_WIDTH'(calc_abs) * HUE_SCALE;
            div_num_d  = DIV_WIDTH'(calc_delta) * SAT_SCALE;
            div_den_d  = (calc_max == 8'd0) ? DIV_ONE : DIV_WIDTH'(calc_max);
            div_rem_d  = '0;
            div_quo_d  = '0;
            step_d     = '0;
            state_d    = DIV_SAT;
         end
         DIV_SAT, DIV_HUE: begin
            div_rem_d = div_rem_step;
            div_num_d = div_num_q << 1;
            div_quo_d = div_quo_step;
            step_d    = step_q + CW'(1);
            if (step_q == LAST_STEP) begin
               step_d = '0;
               if (state_q == DIV_SAT) begin
                  // Saturation done: reload the divider for the hue quotient
                  sat_res_d = 7'(div_quo_step);
                  div_num_d = hue_num_q;
                  div_den_d = (delta_q == 8'd0) ? DIV_ONE : DIV_WIDTH'(delta_q);
                  div_rem_d = '0;
                  div_quo_d = '0;
                  state_d   = DIV_HUE;
               end else begin
                  state_d   = FINAL;
               end
            end
         end
         FINAL: begin
            hue_d        = 9'(hue_calc);
            saturation_d = (delta_q == 8'd0) ? 7'd0 : sat_res_q;
            value_d      = 7'(max_q);
            clamped_d    = clamp_pend_q;
            out_valid_d  = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register update; reset aborts any conversion in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b0;
         red_q        <= '0;
         green_q      <= '0;
         blue_q       <= '0;
         clamp_pend_q <= 1'b0;
         max_q        <= '0;
         delta_q      <= '0;
         diff_neg_q   <= 1'b0;
         sector_q     <= '0;
         hue_num_q    <= '0;
         div_num_q    <= '0;
         div_den_q    <= '0;
         div_rem_q    <= '0;
         div_quo_q    <= '0;
         step_q       <= '0;
         sat_res_q    <= '0;
         out_valid_q  <= 1'b0;
         hue_q        <= '0;
         saturation_q <= '0;
         value_q      <= '0;
         clamped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         clamp_pend_q <= clamp_pend_d;
         max_q        <= max_d;
         delta_q      <= delta_d;
         diff_neg_q   <= diff_neg_d;
         sector_q     <= sector_d;
         hue_num_q    <= hue_num_d;
         div_num_q    <= div_num_d;
         div_den_q    <= div_den_d;
         div_rem_q    <= div_rem_d;
         div_quo_q    <= div_quo_d;
         step_q       <= step_d;
         sat_res_q    <= sat_res_d;
         out_valid_q  <= out_valid_d;
         hue_q        <= hue_d;
         saturation_q <= saturation_d;
         value_q      <= value_d;
         clamped_q    <= clamped_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.hue        = hue_q;
   assign bus.saturation = saturation_q;
   assign bus.value      = value_q;
   assign bus.clamped    = clamped_q;

endmodule
